// File: rtl/mat_pkg.sv
// Shared definitions for the 5x3 result path: dimensions, transmitter states
// and the flat-bus offset of each element.
package mat_pkg;

  localparam int ROWS  = 5;
  localparam int COLS  = 3;
  localparam int EW    = 8;
  localparam int NELEM = ROWS * COLS;
  localparam int MW    = NELEM * EW;
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  // Element (0,0) sits in the MSBs of the flat, row-major bus.
  function automatic int elem_offset(input int r, input int c);
    return (NELEM - 1 - (r * COLS + c)) * EW;
  endfunction

endpackage

// File: rtl/mat_elem_sel.sv
// Combinational selector: picks element (row,col) out of the flat matrix bus.
// Out-of-range indices return zero.
module mat_elem_sel
  import mat_pkg::*;
(
  input  logic [MW-1:0] bus,
  input  logic [RW-1:0] row,
  input  logic [CW-1:0] col,
  output logic [EW-1:0] elem
);

  logic [EW-1:0] elems [NELEM];

  for (genvar gi = 0; gi < NELEM; gi++) begin : g_elem
    assign elems[gi] = bus[elem_offset(gi / COLS, gi % COLS) +: EW];
  end

  always_comb begin
    elem = '0;
    for (int k = 0; k < NELEM; k++) begin
      if (int'(row) == k / COLS && int'(col) == k % COLS) begin
        elem = elems[k];
      end
    end
  end

endmodule

// File: rtl/mat_result_tx.sv
// Captures the 5x3 product bus and streams it row-major over valid/ready,
// tagged with row/col and an end-of-matrix flag. Optional MAT_TX_PARITY_EN adds m_par_o.
module mat_result_tx
  import mat_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [MW-1:0] matrix_i,
  output logic          busy_o,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output logic [EW-1:0] m_data_o,
  output logic [RW-1:0] m_row_o,
  output logic [CW-1:0] m_col_o,
  output logic          m_last_o,
  output logic          done_o
`ifdef MAT_TX_PARITY_EN
  ,
  output logic          m_par_o
`endif
);

  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  tx_state_t     state_reg;
  logic [MW-1:0] shadow_reg;
  logic [RW-1:0] row_reg;
  logic [CW-1:0] col_reg;

  logic [RW-1:0] row_next;
  logic [CW-1:0] col_next;
  logic          last_next;
  logic          handshake;
  logic [MW-1:0] sel_bus;
  logic [RW-1:0] sel_row;
  logic [CW-1:0] sel_col;
  logic [EW-1:0] sel_elem;

  assign m_row_o = row_reg;
  assign m_col_o = col_reg;

  always_comb begin
    handshake = (state_reg == SEND) && m_ready_i;
    col_next  = col_reg + 1'b1;
    row_next  = row_reg;
    if (col_reg == COL_MAX) begin
      col_next = '0;
      row_next = row_reg + 1'b1;
    end
    last_next = (row_next == ROW_MAX) && (col_next == COL_MAX);
    // While idle, look ahead into the incoming bus so (0,0) is registered
    // on the same edge that captures it.
    sel_bus = shadow_reg;
    sel_row = row_next;
    sel_col = col_next;
    if (state_reg == IDLE) begin
      sel_bus = matrix_i;
      sel_row = '0;
      sel_col = '0;
    end
  end

  mat_elem_sel u_sel (
    .bus  (sel_bus),
    .row  (sel_row),
    .col  (sel_col),
    .elem (sel_elem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      shadow_reg <= '0;
      row_reg    <= '0;
      col_reg    <= '0;
      busy_o     <= 1'b0;
      m_valid_o  <= 1'b0;
      m_data_o   <= '0;
      m_last_o   <= 1'b0;
      done_o     <= 1'b0;
`ifdef MAT_TX_PARITY_EN
      m_par_o    <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (load_i) begin
            state_reg  <= SEND;
            shadow_reg <= matrix_i;
            row_reg    <= '0;
            col_reg    <= '0;
            busy_o     <= 1'b1;
            m_valid_o  <= 1'b1;
            m_data_o   <= sel_elem;
            m_last_o   <= 1'b0;
`ifdef MAT_TX_PARITY_EN
            m_par_o    <= ^sel_elem;
`endif
          end
        end
        SEND: begin
          if (handshake) begin
            if (m_last_o) begin
              state_reg <= IDLE;
              busy_o    <= 1'b0;
              m_valid_o <= 1'b0;
              m_last_o  <= 1'b0;
              done_o    <= 1'b1;
            end else begin
              row_reg  <= row_next;
              col_reg  <= col_next;
              m_data_o <= sel_elem;
              m_last_o <= last_next;
`ifdef MAT_TX_PARITY_EN
              m_par_o  <= ^sel_elem;
`endif
            end
          end
        end
      endcase
    end
  end

endmodule
